scan_register_bank: RTL

SCAN_REGISTER_BANK -- requirements
Module: scan_register_bank

---
 rtl/scan_bank_pkg.sv | 16 +
 rtl/scan_chain_seg.sv | 53 +++++
 rtl/scan_register_bank.sv | 115 +++++++++++
 3 files changed

// File: rtl/scan_bank_pkg.sv
// Shared constants and helpers for the scan register bank.
//   MISR_POLY  : feedback polynomial of the scan-out signature register
//   MISR_WIDTH : signature width in bits
//   chain_lsb  : lowest bank bit index owned by a given chain
package scan_bank_pkg;

  localparam int unsigned MISR_WIDTH = 32;
  localparam logic [MISR_WIDTH-1:0] MISR_POLY = 32'h04C11DB7;

  // Chain c owns bank bits [c*chain_len +: chain_len].
  function automatic int unsigned chain_lsb(input int unsigned chain,
                                            input int unsigned chain_len);
    return chain * chain_len;
  endfunction

endpackage

// File: rtl/scan_chain_seg.sv
// One scan chain segment: LEN flops with a mux-D input selecting shift or capture.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   scan_enable  : shift one position toward the LSB (priority over enable)
//   enable       : capture parallel data
//   scan_in      : serial input, enters at the MSB
//   capture      : parallel capture data
//   data         : current segment contents
//   scan_out     : current LSB (direct from the flop)
module scan_chain_seg #(
  parameter int unsigned LEN = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scan_enable,
  input  logic           enable,
  input  logic           scan_in,
  input  logic [LEN-1:0] capture,
  output logic [LEN-1:0] data,
  output logic           scan_out
);

  logic [LEN-1:0] data_q;
  logic [LEN-1:0] data_d;
  logic [LEN-1:0] shift_val;

  if (LEN == 1) begin : g_len1
    assign shift_val = scan_in;
  end else begin : g_lenn
    assign shift_val = {scan_in, data_q[LEN-1:1]};
  end

  always_comb begin
    data_d = data_q;
    if (scan_enable) begin
      data_d = shift_val;
    end else if (enable) begin
      data_d = capture;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data     = data_q;
  assign scan_out = data_q[0];

endmodule

// File: rtl/scan_register_bank.sv
// Scannable register bank split into NUM_CHAINS independent scan chains, with a
// shift counter that pulses shift_done after every full chain-length shift and an
// optional scan-out signature register (MISR).
// Optional feature macro: SCAN_MISR_EN (MISR present; otherwise signature is 0).
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   enable       : functional capture of inputs
//   inputs       : functional data in
//   outputs      : bank contents
//   scan_enable  : shift mode (priority over enable)
//   scan_in      : serial input per chain
//   scan_out     : serial output per chain (chain LSB)
//   shift_done   : registered pulse after each complete CHAIN_LEN shift
//   misr_clear   : synchronous signature clear
//   signature    : compacted scan_out signature
module scan_register_bank
  import scan_bank_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_CHAINS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      inputs,
  output logic [WIDTH-1:0]      outputs,
  input  logic                  scan_enable,
  input  logic [NUM_CHAINS-1:0] scan_in,
  output logic [NUM_CHAINS-1:0] scan_out,
  output logic                  shift_done,
  input  logic                  misr_clear,
  output logic [MISR_WIDTH-1:0] signature
);

  localparam int unsigned CHAIN_LEN = WIDTH / NUM_CHAINS;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    scan_chain_seg #(
      .LEN (CHAIN_LEN)
    ) u_seg (
      .clk         (clk),
      .reset       (reset),
      .scan_enable (scan_enable),
      .enable      (enable),
      .scan_in     (scan_in[c]),
      .capture     (inputs[chain_lsb(c, CHAIN_LEN) +: CHAIN_LEN]),
      .data        (outputs[chain_lsb(c, CHAIN_LEN) +: CHAIN_LEN]),
      .scan_out    (scan_out[c])
    );
  end

  // Shift counter: any non-shift cycle discards a partial sequence.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;

  always_comb begin
    cnt_d  = '0;
    done_d = 1'b0;
    if (scan_enable) begin
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign shift_done = done_q;

`ifdef SCAN_MISR_EN
  logic [MISR_WIDTH-1:0] misr_q;
  logic [MISR_WIDTH-1:0] misr_d;

  // Compacts the pre-shift scan_out value of every shift cycle.
  always_comb begin
    misr_d = misr_q;
    if (misr_clear) begin
      misr_d = '0;
    end else if (scan_enable) begin
      misr_d = {misr_q[MISR_WIDTH-2:0], 1'b0}
             ^ (misr_q[MISR_WIDTH-1] ? MISR_POLY : '0)
             ^ MISR_WIDTH'(scan_out);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign signature = misr_q;
`else
  logic unused_misr_clear;
  assign unused_misr_clear = misr_clear;
  assign signature         = '0;
`endif

endmodule
